// File: rtl/register_dump_controller_pkg.sv
// rtl/register_dump_controller_pkg.sv - shared states and frame constants for the register dump controller
package register_dump_controller_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_HALT_WAIT = 3'd1;
    localparam logic [2:0] ST_SEND_HDR  = 3'd2;
    localparam logic [2:0] ST_LOAD_REG  = 3'd3;
    localparam logic [2:0] ST_SEND_REG  = 3'd4;
    localparam logic [2:0] ST_SEND_PC   = 3'd5;
    localparam logic [2:0] ST_RELEASE   = 3'd6;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
    localparam int         REG_BYTES           = 4;
    localparam int         PC_BYTES            = 2;

    function automatic int frame_len(input int num_regs, input int send_pc);
        return 1 + REG_BYTES * num_regs + PC_BYTES * send_pc;
    endfunction

endpackage

// File: rtl/register_dump_controller_serializer.sv
// rtl/register_dump_controller_serializer.sv - 32-bit MSB-first byte serializer with byte counter
module dump_byte_serializer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic        shift_i,
    input  logic [1:0]  last_cnt_i,
    output logic [7:0]  byte_o,
    output logic        last_byte_o
);

    logic [31:0] shreg_q;
    logic [1:0]  cnt_q;

    // A load wins over a shift so the final byte of one word can hand over to the next word in one edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            shreg_q <= load_data_i;
            cnt_q   <= '0;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[23:0], 8'h00};
            if (cnt_q != 2'd3) begin
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    assign byte_o      = shreg_q[31:24];
    assign last_byte_o = (cnt_q == last_cnt_i);

endmodule

// File: rtl/register_dump_controller.sv
// rtl/register_dump_controller.sv - halts the pipeline and streams header, register file and PC bytes to UART
import register_dump_controller_pkg::*;

module register_dump_controller #(
    parameter int         NUM_REGS    = 32,
    parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT,
    parameter bit         SEND_PC     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        dump_req,
    input  logic        halt_ack,
    input  logic [31:0] reg_data,
    input  logic [10:0] pc_value,
    input  logic        tx_ready,
    output logic        halt,
    output logic [4:0]  reg_sel,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    logic [2:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        xfer;
    logic        ser_load;
    logic [31:0] ser_data;
    logic        ser_shift;
    logic [1:0]  ser_last_cnt;
    logic [7:0]  ser_byte;
    logic        ser_last;
    logic        sending;

    assign sending = (state_q == ST_SEND_REG) || (state_q == ST_SEND_PC);
    assign xfer    = tx_valid && tx_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ser_load = 1'b0;
        ser_data = reg_data;
        case (state_q)
            ST_IDLE:      if (dump_req) state_d = ST_HALT_WAIT;
            ST_HALT_WAIT: if (halt_ack) state_d = ST_SEND_HDR;
            ST_SEND_HDR: begin
                if (xfer) begin
                    idx_d   = '0;
                    state_d = ST_LOAD_REG;
                end
            end
            ST_LOAD_REG: begin
                ser_load = 1'b1;
                state_d  = ST_SEND_REG;
            end
            ST_SEND_REG: begin
                if (xfer && ser_last) begin
                    if (idx_q == LAST_IDX) begin
                        if (SEND_PC) begin
                            // PC goes left-aligned so the serializer emits {5'b0,pc[10:8]} then pc[7:0].
                            ser_load = 1'b1;
                            ser_data = {5'b0, pc_value, 16'h0000};
                            state_d  = ST_SEND_PC;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_LOAD_REG;
                    end
                end
            end
            ST_SEND_PC:   if (xfer && ser_last) state_d = ST_RELEASE;
            ST_RELEASE:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign ser_shift    = xfer && sending;
    assign ser_last_cnt = (state_q == ST_SEND_PC) ? 2'd1 : 2'd3;

    dump_byte_serializer u_ser (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_i      (ser_load),
        .load_data_i (ser_data),
        .shift_i     (ser_shift),
        .last_cnt_i  (ser_last_cnt),
        .byte_o      (ser_byte),
        .last_byte_o (ser_last)
    );

    // All outputs decode from registered state, so an asynchronous reset clears them at once.
    assign halt     = (state_q == ST_HALT_WAIT) || (state_q == ST_SEND_HDR) ||
                      (state_q == ST_LOAD_REG) || sending;
    assign busy     = halt;
    assign done     = (state_q == ST_RELEASE);
    assign tx_valid = (state_q == ST_SEND_HDR) || sending;
    assign tx_data  = (state_q == ST_SEND_HDR) ? HEADER_BYTE : (sending ? ser_byte : 8'h00);
    assign reg_sel  = idx_q;

endmodule

// File: doc/register_dump_controller.md
Name: register_dump_controller

Overview:
Debug controller that freezes the pipeline and streams a snapshot of the 32-entry register file plus the current PC to the UART transmitter, byte by byte. It sits between the decode stage's register-file debug outputs, the pipeline halt/stall logic and the UART TX front-end. It sequences halt, waits for the pipeline to drain, reads registers one at a time through an external 32:1 select mux, serializes each register and then releases the pipeline.

Parameters:
NUM_REGS, 32, number of registers dumped, indices 0..NUM_REGS-1.
HEADER_BYTE, 8'hA5, first byte of every dump frame.
SEND_PC, 1, when 1 append the 11-bit PC as 2 bytes after the registers; when 0 omit them.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
dump_req  in  1  single-cycle request to start a dump.
halt_ack  in  1  pipeline drained and frozen; no register writes in flight.
reg_data  in  32  value of register reg_sel, from the external combinational mux.
pc_value  in  11  current PC, valid while halted.
tx_ready  in  1  UART front-end can accept a byte.
halt  out  1  freeze request to the fetch and decode stages.
reg_sel  out  5  register index presented to the mux.
tx_data  out  8  byte to transmit.
tx_valid  out  1  tx_data is valid.
busy  out  1  dump in progress, from request accept through release.
done  out  1  one-cycle pulse when a dump completes.

Behaviour:
- Reset, asynchronous: state IDLE. halt, tx_valid, busy and done are 0. reg_sel, tx_data and all counters are 0.
- Byte handshake: a byte transfers on a rising edge where tx_valid=1 and tx_ready=1. Once tx_valid is high, tx_data is held stable and tx_valid stays high until the transfer.
- IDLE: on dump_req=1, go to HALT_WAIT next cycle with halt=1 and busy=1. Both are registered, so they appear 1 cycle after the request.
- HALT_WAIT: hold halt=1. When halt_ack=1 is sampled, go to SEND_HDR. There is no timeout; the state waits indefinitely.
- SEND_HDR: tx_data=HEADER_BYTE, tx_valid=1. On transfer, set reg index to 0 and go to LOAD_REG.
- LOAD_REG (1 cycle): reg_sel=index, tx_valid=0. Capture reg_data into a 32-bit shift register and clear the byte counter, then go to SEND_REG.
- SEND_REG: tx_data is the shift register's [31:24], so bytes go MSB first. On transfer, shift left by 8 and increment the byte counter.
  - After the 4th byte: if index==NUM_REGS-1, go to SEND_PC when SEND_PC=1, else to RELEASE.
  - Otherwise increment index and go to LOAD_REG.
  - With tx_ready held high, each register costs 5 cycles (1 load + 4 bytes).
- SEND_PC: send 2 bytes, first {5'b0, pc_value[10:8]}, then pc_value[7:0]. pc_value is captured on entry. After the 2nd transfer, go to RELEASE.
- RELEASE (1 cycle): halt=0, busy=0, done=1. Return to IDLE.
- dump_req while busy=1 is ignored and is not queued.
- halt_ack dropping after HALT_WAIT has no effect; it is only sampled in HALT_WAIT.
- Frame length is 1 + 4*NUM_REGS + 2*SEND_PC bytes, 131 bytes at defaults.
- Reset mid-dump: outputs return to reset values at once. halt drops asynchronously, the partial frame is abandoned and nothing resumes.
- The counters never wrap. The index stops at NUM_REGS-1 and the byte counter is 2 bits, cleared in LOAD_REG.

Decomposition:
- Shared package:
  - state enum: IDLE, HALT_WAIT, SEND_HDR, LOAD_REG, SEND_REG, SEND_PC, RELEASE.
  - constants: HEADER_BYTE default, FRAME_LEN function of NUM_REGS and SEND_PC, REG_BYTES=4.
- One sub-module, dump_byte_serializer: load, 32-bit shift register, byte counter, last_byte flag and tx_data output. It is shared by SEND_REG, and by SEND_PC with the PC loaded left-aligned.

Test Plan:
1. Basic dump.
   - Stimulus: r_i = 32'h01010101*i, r1=32'h11223344, pc=11'h3A5, tx_ready=1 always, halt_ack 3 cycles after halt rises, single dump_req.
   - Response: exactly 131 bytes: A5, then r0 as 00 00 00 00, then r1 as 11 22 33 44, ..., then 03 A5. done pulses once. halt is 0 the cycle after done.
2. Backpressure.
   - Stimulus: tx_ready toggled pseudo-randomly, 30% high.
   - Response: tx_data never changes while tx_valid=1 and tx_ready=0. The byte stream is identical to scenario 1.
3. Halt wait.
   - Stimulus: halt_ack held 0 for 100 cycles.
   - Response: halt=1, tx_valid=0 throughout. The header appears the cycle after halt_ack rises.
4. Request while busy.
   - Stimulus: dump_req pulsed at byte 10 and at byte 130.
   - Response: still exactly one 131-byte frame and one done pulse.
5. Reset mid-dump.
   - Stimulus: assert reset_n=0 after byte 50.
   - Response: halt, tx_valid and busy are 0 immediately. A new dump_req after release yields a complete frame starting with A5.
6. SEND_PC=0, NUM_REGS=4.
   - Stimulus: a single dump_req.
   - Response: 17 bytes total, and done comes 2 bytes earlier than with PC enabled.
